// File: rtl/bg_pkg.sv
// Shared constants and types for the background scroll reader.
// Image geometry, offset bus type and layer encoding.
package bg_pkg;

  localparam int IMG_W    = 640;
  localparam int IMG_H    = 480;
  localparam int ADDR_W   = 19;
  localparam int COLOR_W  = 8;
  localparam int SCREEN_W = 640;

  typedef logic [$clog2(SCREEN_W)-1:0] offset_t;

  typedef enum logic {
    COPY1 = 1'b0,
    COPY2 = 1'b1
  } layer_e;

endpackage

// File: rtl/bg_addr_gen.sv
// Frame-latched offset shadows and stage-1 address generation: layer select,
// column/row arithmetic with saturation and outside detection, shift-add ROM address.
module bg_addr_gen #(
  parameter int IMG_W  = bg_pkg::IMG_W,
  parameter int IMG_H  = bg_pkg::IMG_H,
  parameter int ADDR_W = bg_pkg::ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_start,
  input  logic [9:0]        i_pixel_x,
  input  logic [9:0]        i_pixel_y,
  input  logic              i_pixel_active,
  input  logic [9:0]        i_back1_x,
  input  logic [9:0]        i_back1_y,
  input  logic [9:0]        i_back2_x,
  input  logic [9:0]        i_back2_y,
  input  logic [9:0]        i_back1_skip_x,
  input  logic [9:0]        i_back2_skip_x,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic              o_layer,
  output logic              o_outside
);
  import bg_pkg::*;

  offset_t          r_b1x, r_b1y, r_b2x, r_b2y, r_b1skip, r_b2skip;
  logic [ADDR_W-1:0] r_rom_addr;
  layer_e           w_layer;
  logic [10:0]      w_col_raw;
  logic [10:0]      w_col;
  logic [10:0]      w_row;
  logic             w_outside;
  logic [ADDR_W-1:0] w_addr;

  // row * IMG_W as a sum of shifted rows, one term per set bit of IMG_W
  function automatic logic [ADDR_W-1:0] mul_img_w(input logic [10:0] row);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      if (IMG_W[b]) acc = acc + (ADDR_W'(row) << b);
    end
    return acc;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_b1x    <= '0;
      r_b1y    <= '0;
      r_b2x    <= '0;
      r_b2y    <= '0;
      r_b1skip <= '0;
      r_b2skip <= '0;
    end else if (i_frame_start) begin
      r_b1x    <= i_back1_x;
      r_b1y    <= i_back1_y;
      r_b2x    <= i_back2_x;
      r_b2y    <= i_back2_y;
      r_b1skip <= i_back1_skip_x;
      r_b2skip <= i_back2_skip_x;
    end
  end

  always_comb begin
    w_layer   = (i_pixel_x >= r_b1x) ? COPY1 : COPY2;
    w_col_raw = '0;
    w_row     = '0;
    w_outside = 1'b0;
    if (w_layer == COPY1) begin
      w_col_raw = {1'b0, i_pixel_x} - {1'b0, r_b1x} + {1'b0, r_b1skip};
      w_row     = {1'b0, i_pixel_y} - {1'b0, r_b1y};
      w_outside = (i_pixel_y < r_b1y);
    end else begin
      w_col_raw = {1'b0, i_pixel_x} - {1'b0, r_b2x} + {1'b0, r_b2skip};
      w_row     = {1'b0, i_pixel_y} - {1'b0, r_b2y};
      w_outside = (i_pixel_x < r_b2x) || (i_pixel_y < r_b2y);
    end
    if (w_row >= 11'(IMG_H)) w_outside = 1'b1;
    w_col  = (w_col_raw >= 11'(IMG_W)) ? 11'(IMG_W - 1) : w_col_raw;
    w_addr = w_outside ? '0 : mul_img_w(w_row) + ADDR_W'(w_col);
  end

  // Blanking pixels leave the address untouched so the ROM sees no spurious reads
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            r_rom_addr <= '0;
    else if (i_pixel_active) r_rom_addr <= w_addr;
  end

  assign o_rom_addr = r_rom_addr;
  assign o_layer    = w_layer;
  assign o_outside  = w_outside;

endmodule

// File: rtl/background_scroll_reader.sv
// Background scroll read path: scan position -> ROM address -> aligned colour.
// Optional colour-key transparency output enabled by macro BG_COLORKEY_EN.
module background_scroll_reader #(
  parameter int IMG_W   = bg_pkg::IMG_W,
  parameter int IMG_H   = bg_pkg::IMG_H,
  parameter int ADDR_W  = bg_pkg::ADDR_W,
  parameter int COLOR_W = bg_pkg::COLOR_W,
  parameter int ROM_LAT = 1
`ifdef BG_COLORKEY_EN
  ,
  parameter logic [COLOR_W-1:0] KEY_COLOR = COLOR_W'(8'hE3)
`endif
) (
  input  logic               pixelClOCK,
  input  logic               RESETn,
  input  logic               frameStart,
  input  logic [9:0]         pixelX,
  input  logic [9:0]         pixelY,
  input  logic               pixelActive,
  input  logic [9:0]         BACK1X,
  input  logic [9:0]         BACK1Y,
  input  logic [9:0]         BACK2X,
  input  logic [9:0]         BACK2Y,
  input  logic [9:0]         BACK1SKIPX,
  input  logic [9:0]         BACK2SKIPX,
  output logic [ADDR_W-1:0]  romAddr,
  input  logic [COLOR_W-1:0] romData,
  output logic [COLOR_W-1:0] bgColor,
  output logic               bgValid,
  output logic               bgLayer
`ifdef BG_COLORKEY_EN
  ,
  output logic               bgOpaque
`endif
);
  import bg_pkg::*;

  logic               w_layer;
  logic               w_outside;
  logic [ROM_LAT:0]   r_act_d;
  logic [ROM_LAT:0]   r_layer_d;
  logic [ROM_LAT:0]   r_out_d;
  logic [COLOR_W-1:0] r_color;
  logic               r_valid;
  logic               r_layer;
  logic               w_show;

  bg_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_clk          (pixelClOCK),
    .i_rst_n        (RESETn),
    .i_frame_start  (frameStart),
    .i_pixel_x      (pixelX),
    .i_pixel_y      (pixelY),
    .i_pixel_active (pixelActive),
    .i_back1_x      (BACK1X),
    .i_back1_y      (BACK1Y),
    .i_back2_x      (BACK2X),
    .i_back2_y      (BACK2Y),
    .i_back1_skip_x (BACK1SKIPX),
    .i_back2_skip_x (BACK2SKIPX),
    .o_rom_addr     (romAddr),
    .o_layer        (w_layer),
    .o_outside      (w_outside)
  );

  // Stage 0 captures alongside romAddr; the last stage lines up with romData
  always_ff @(posedge pixelClOCK or negedge RESETn) begin
    if (!RESETn) begin
      r_act_d   <= '0;
      r_layer_d <= '0;
      r_out_d   <= '0;
    end else begin
      r_act_d[0]   <= pixelActive;
      r_layer_d[0] <= w_layer;
      r_out_d[0]   <= w_outside;
      for (int i = 1; i <= ROM_LAT; i++) begin
        r_act_d[i]   <= r_act_d[i-1];
        r_layer_d[i] <= r_layer_d[i-1];
        r_out_d[i]   <= r_out_d[i-1];
      end
    end
  end

  assign w_show = r_act_d[ROM_LAT] && !r_out_d[ROM_LAT];

  always_ff @(posedge pixelClOCK or negedge RESETn) begin
    if (!RESETn) begin
      r_color <= '0;
      r_valid <= 1'b0;
      r_layer <= 1'b0;
    end else begin
      r_color <= w_show ? romData : '0;
      r_valid <= r_act_d[ROM_LAT];
      r_layer <= r_layer_d[ROM_LAT];
    end
  end

  assign bgColor = r_color;
  assign bgValid = r_valid;
  assign bgLayer = r_layer;

`ifdef BG_COLORKEY_EN
  logic r_opaque;

  always_ff @(posedge pixelClOCK or negedge RESETn) begin
    if (!RESETn) r_opaque <= 1'b0;
    else         r_opaque <= w_show && (romData != KEY_COLOR);
  end

  assign bgOpaque = r_opaque;
`endif

endmodule

// File: tb/tb_background_scroll_reader.sv
// Bench for background_scroll_reader: table of pixel vectors with hand-computed
// expectations fed through a latency-aware scoreboard, plus reset/latency sequences.
module tb_background_scroll_reader;

  localparam int AW = 19;
  localparam int CW = 8;
  localparam int OW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frameStart = 1'b0;
  logic [9:0]    pixelX = '0, pixelY = '0;
  logic          pixelActive = 1'b0;
  logic [9:0]    BACK1X = '0, BACK1Y = '0, BACK2X = '0, BACK2Y = '0;
  logic [9:0]    BACK1SKIPX = '0, BACK2SKIPX = '0;
  logic [AW-1:0] romAddr;
  logic [CW-1:0] romData = '0;
  logic [CW-1:0] bgColor;
  logic          bgValid;
  logic          bgLayer;
`ifdef BG_COLORKEY_EN
  logic          bgOpaque;
`endif

  background_scroll_reader dut (
    .pixelClOCK  (clk),
    .RESETn      (rst_n),
    .frameStart  (frameStart),
    .pixelX      (pixelX),
    .pixelY      (pixelY),
    .pixelActive (pixelActive),
    .BACK1X      (BACK1X),
    .BACK1Y      (BACK1Y),
    .BACK2X      (BACK2X),
    .BACK2Y      (BACK2Y),
    .BACK1SKIPX  (BACK1SKIPX),
    .BACK2SKIPX  (BACK2SKIPX),
    .romAddr     (romAddr),
    .romData     (romData),
    .bgColor     (bgColor),
    .bgValid     (bgValid),
    .bgLayer     (bgLayer)
`ifdef BG_COLORKEY_EN
    ,
    .bgOpaque    (bgOpaque)
`endif
  );

  // Clock and a one-cycle ROM whose contents are the low address byte
  always #5 clk = ~clk;
  always @(posedge clk) romData <= romAddr[7:0];

  typedef struct {
    bit         fs;
    logic [9:0] b1x, b1y, b2x, b2y, s1, s2;
    logic [9:0] px, py;
    bit         act;
    logic [AW-1:0] e_addr;
    logic [CW-1:0] e_col;
    bit         e_layer;
    bit         e_out;
  } vec_t;

  logic [AW-1:0] exp_q[$];
  int            exp_due[$];
  logic [OW-1:0] out_q[$];
  int            out_due[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  vec_t          tbl[26];
  vec_t          idle;

  function automatic vec_t mkp(int px, int py, bit act, int addr, int col, bit layer, bit out);
    vec_t v;
    v.fs  = 1'b0;
    v.b1x = 10'($urandom_range(1023, 0));
    v.b1y = 10'($urandom_range(1023, 0));
    v.b2x = 10'($urandom_range(1023, 0));
    v.b2y = 10'($urandom_range(1023, 0));
    v.s1  = 10'($urandom_range(1023, 0));
    v.s2  = 10'($urandom_range(1023, 0));
    v.px = 10'(px); v.py = 10'(py); v.act = act;
    v.e_addr = AW'(addr); v.e_col = CW'(col); v.e_layer = layer; v.e_out = out;
    return v;
  endfunction

  function automatic vec_t mkf(int b1x, int b1y, int b2x, int b2y, int s1, int s2,
                               int px, int py, bit act, int addr, int col, bit layer, bit out);
    vec_t v;
    v = mkp(px, py, act, addr, col, layer, out);
    v.fs  = 1'b1;
    v.b1x = 10'(b1x); v.b1y = 10'(b1y); v.b2x = 10'(b2x); v.b2y = 10'(b2y);
    v.s1  = 10'(s1);  v.s2  = 10'(s2);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Scoreboard: compare every entry whose due cycle is now
  task automatic check_due();
    logic [OW-1:0] e;
    while (exp_due.size() > 0 && exp_due[0] == cyc) begin
      void'(exp_due.pop_front());
      chk("romAddr", 32'(romAddr), 32'(exp_q.pop_front()));
    end
    while (out_due.size() > 0 && out_due[0] == cyc) begin
      void'(out_due.pop_front());
      e = out_q.pop_front();
      chk("bgValid", 32'(bgValid), 32'(e[9]));
      chk("bgLayer", 32'(bgLayer), 32'(e[8]));
      chk("bgColor", 32'(bgColor), 32'(e[7:0]));
`ifdef BG_COLORKEY_EN
      chk("bgOpaque", 32'(bgOpaque), 32'(e[10]));
`endif
    end
  endtask

  // Driver: one pixel per negedge; expected values queued with their latency
  task automatic tick(input bit push, input vec_t v);
    bit opq;
    @(negedge clk);
    cyc++;
    check_due();
    frameStart  = v.fs;
    BACK1X = v.b1x; BACK1Y = v.b1y; BACK2X = v.b2x; BACK2Y = v.b2y;
    BACK1SKIPX = v.s1; BACK2SKIPX = v.s2;
    pixelX = v.px; pixelY = v.py; pixelActive = v.act;
    if (push) begin
      opq = v.act && !v.e_out && (v.e_col != 8'hE3);
      exp_q.push_back(v.e_addr);
      exp_due.push_back(cyc + 1);
      out_q.push_back({opq, v.act, v.e_layer, v.e_col});
      out_due.push_back(cyc + 3);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_romAddr"}, 32'(romAddr), 32'd0);
    chk({tag, "_bgColor"}, 32'(bgColor), 32'd0);
    chk({tag, "_bgValid"}, 32'(bgValid), 32'd0);
    chk({tag, "_bgLayer"}, 32'(bgLayer), 32'd0);
`ifdef BG_COLORKEY_EN
    chk({tag, "_bgOpaque"}, 32'(bgOpaque), 32'd0);
`endif
  endtask

  initial begin
    idle = mkf(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    idle.fs = 1'b0;

    // offsets: b1x,b1y,b2x,b2y,skip1,skip2 | pixel x,y,active | addr,colour,layer,outside
    tbl[0]  = mkp(5, 0, 1, 5, 8'h05, 0, 0);
    tbl[1]  = mkf(100, 0, 0, 0, 0, 0, 5, 0, 1, 5, 8'h05, 0, 0);
    tbl[2]  = mkp(150, 0, 1, 50, 8'h32, 0, 0);
    tbl[3]  = mkp(50, 0, 1, 50, 8'h32, 1, 0);
    tbl[4]  = mkp(300, 300, 0, 50, 8'h00, 0, 0);
    tbl[5]  = mkp(10, 2, 1, 1290, 8'h0A, 1, 0);
    tbl[6]  = mkf(600, 0, 0, 0, 0, 35, 10, 2, 1, 1290, 8'h0A, 1, 0);
    tbl[7]  = mkp(599, 0, 1, 634, 8'h7A, 1, 0);
    tbl[8]  = mkp(600, 0, 1, 0, 8'h00, 0, 0);
    tbl[9]  = mkp(639, 1, 1, 679, 8'hA7, 0, 0);
    tbl[10] = mkp(620, 479, 1, 306580, 8'h94, 0, 0);
    tbl[11] = mkf(0, 10, 0, 0, 630, 0, 0, 0, 1, 35, 8'h23, 1, 0);
    tbl[12] = mkp(20, 15, 1, 3839, 8'hFF, 0, 0);
    tbl[13] = mkp(20, 5, 1, 0, 8'h00, 0, 1);
    tbl[14] = mkp(0, 489, 1, 307190, 8'hF6, 0, 0);
    tbl[15] = mkp(0, 490, 1, 0, 8'h00, 0, 1);
    tbl[16] = mkp(5, 20, 0, 0, 8'h00, 0, 0);
    tbl[17] = mkf(640, 0, 0, 0, 0, 0, 1, 20, 1, 7031, 8'h77, 0, 0);
    tbl[18] = mkp(300, 7, 1, 4780, 8'hAC, 1, 0);
    tbl[19] = mkp(639, 479, 1, 307199, 8'hFF, 1, 0);
    tbl[20] = mkf(640, 0, 100, 0, 0, 0, 50, 0, 1, 50, 8'h32, 1, 0);
    tbl[21] = mkp(50, 0, 1, 0, 8'h00, 1, 1);
    tbl[22] = mkp(150, 3, 1, 1970, 8'hB2, 1, 0);
    tbl[23] = mkp(0, 0, 0, 1970, 8'h00, 1, 0);
    tbl[24] = mkp(151, 3, 1, 1971, 8'hB3, 1, 0);
    tbl[25] = mkp(327, 0, 1, 227, 8'hE3, 1, 0);

    // Power-on reset
    repeat (2) @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;

    foreach (tbl[i]) tick(1'b1, tbl[i]);
    repeat (4) tick(1'b0, idle);

    // Asynchronous reset in the middle of a frame
    tick(1'b0, mkp(327, 0, 1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("pre_reset_romAddr", 32'(romAddr), 32'd227);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    pixelActive = 1'b0;
    frameStart  = 1'b0;
    exp_q.delete(); exp_due.delete(); out_q.delete(); out_due.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Shadows are cleared by reset; then first-pixel latency
    tick(1'b1, mkp(5, 0, 1, 5, 8'h05, 0, 0));
    tick(1'b1, mkp(10, 2, 1, 1290, 8'h0A, 0, 0));
    @(posedge clk);
    #1;
    chk("latency_romAddr_t1", 32'(romAddr), 32'd1290);
    repeat (4) tick(1'b0, idle);

    chk("scoreboard_drained", 32'(exp_q.size() + out_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/background_scroll_reader.md
Name: background_scroll_reader

Overview:
- Read side of the background scroll interface: consumes the per-frame layer offsets produced by the background animation block (BACK1X/BACK1Y, BACK2X/BACK2Y, BACK1SKIPX/BACK2SKIPX).
- Converts the live VGA scan position into background image ROM addresses and returns the aligned background pixel colour.
- Sits between the VGA timing generator, the background image ROM and the sprite compositor.
- Offsets are shadow-latched once per frame so a scroll update never tears mid-frame.

Parameters:
IMG_W, 640, background image width in pixels
IMG_H, 480, background image height in pixels
ADDR_W, 19, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
COLOR_W, 8, ROM pixel / output colour width
ROM_LAT, 1, cycles from romAddr registered to romData valid (1..4)

Ports:
pixelClOCK  in  1  pixel clock; all logic on its rising edge
RESETn  in  1  asynchronous active-low reset
frameStart  in  1  one-cycle pulse at start of vertical blank
pixelX  in  10  current scan column
pixelY  in  10  current scan row
pixelActive  in  1  high in the visible area
BACK1X  in  10  screen column where copy 1 starts
BACK1Y  in  10  screen row where copy 1 starts
BACK2X  in  10  screen column where copy 2 starts
BACK2Y  in  10  screen row where copy 2 starts
BACK1SKIPX  in  10  image columns skipped at the left of copy 1
BACK2SKIPX  in  10  image columns skipped at the left of copy 2
romAddr  out  ADDR_W  background ROM read address
romData  in  COLOR_W  ROM read data
bgColor  out  COLOR_W  background pixel colour, aligned to bgValid
bgValid  out  1  bgColor corresponds to an active pixel
bgLayer  out  1  0 = copy 1, 1 = copy 2

Behaviour:
Reset
- All outputs, shadow registers and pipeline registers clear to 0 asynchronously.
- Release is synchronous to pixelClOCK.

Offset shadow
- On a cycle with frameStart=1, all six offset inputs are copied into shadow registers.
- Pixels sampled in that same cycle still use the old shadows; the new values apply from the next cycle.
- Offset input changes between frameStart pulses are ignored.

Stage 1 (sampled at cycle t; romAddr registered at t+1)
- Layer select: copy 1 if pixelX >= sB1X, else copy 2.
- Column:
  - copy 1: col = pixelX - sB1X + sB1SKIPX
  - copy 2: col = pixelX - sB2X + sB2SKIPX, with pixelX < sB2X treated as outside the image
  - computed at 11 bits; col >= IMG_W saturates to IMG_W-1.
- Row: row = pixelY - sBnY for the selected copy. pixelY < sBnY or row >= IMG_H sets the outside flag.
- romAddr = row*IMG_W + col, computed by shift-add (row<<9 + row<<7 when IMG_W=640); no multiplier.
- When outside, romAddr is 0.
- When pixelActive=0, romAddr holds its previous value.

Delay line
- pixelActive, layer and outside are delayed ROM_LAT+1 cycles to align with romData.

Output (registered at t+2+ROM_LAT; default latency 3)
- bgValid = delayed pixelActive.
- bgColor = 0 if outside or not active, else romData.
- bgLayer = delayed layer.

Boundary cases
- sB1X=640: copy 2 fills the screen. With sB2X=0 and sB2SKIPX=0, col = pixelX.
- sB1X=0: copy 1 only, col = pixelX + sB1SKIPX.
- frameStart during active video is legal.
- pixelActive toggling every cycle is legal; the pipeline never stalls.

Optional Feature:
- Macro BG_COLORKEY_EN.
  - When defined: adds parameter KEY_COLOR (default 8'hE3) and output bgOpaque (1 bit, reset 0, same timing as bgColor).
  - bgOpaque = bgValid && !outside && romData != KEY_COLOR; the compositor shows the layer behind when it is 0.
- When undefined: the port and compare logic are absent and behaviour is otherwise identical.

Decomposition:
- Package bg_pkg holds:
  - constants IMG_W, IMG_H, ADDR_W, COLOR_W
  - localparam SCREEN_W=640
  - typedef for the 10-bit offset bus
  - the layer encoding (COPY1=0, COPY2=1)
- One sub-module, bg_addr_gen: shadow registers plus stage 1 (layer select, column/row arithmetic, saturation, shift-add address).
- The top module holds the delay line and output stage.

Test Plan:
1. Reset: assert RESETn=0 mid-frame -> all outputs 0 the same cycle. After release with no frameStart, shadows are 0, so pixel (5,0) gives romAddr=5.
2. Offset latch: BACK1X=100 with frameStart, then BACK1X=200 mid-frame without frameStart -> pixel (150,0) uses copy 1, romAddr=50, bgLayer=0.
3. Latency: drive pixel (10,2) active with ROM_LAT=1 and ROM model data=addr[7:0] -> romAddr=1290 at t+1; bgColor=8'h0A, bgValid=1 at t+3.
4. Wrap split: sB1X=600, sB2X=0, sB2SKIPX=35 -> pixel (599,0) gives copy 2, col 634. Pixel (600,0) gives copy 1, col 0.
5. Saturation/outside: sB1X=0, sB1SKIPX=630, pixel (20,0) -> col 639. Pixel with pixelY < sB1Y -> bgColor=0, bgValid=1.
6. BG_COLORKEY_EN: romData=8'hE3 -> bgOpaque=0; romData=8'h1C -> bgOpaque=1.
